// File: rtl/decode_stage_pipe.sv
// Registered RISC-V decode stage between IF and EX.
// The raw word and PC are held (output register plus optional skid entry), and
// the decoded bundle is derived from the held output word, so stalls keep it stable.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | output register invalid
// S_ONE   | output register valid, skid entry empty
// S_FULL  | output register and skid entry both valid
module decode_stage_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [5:0]      out_type,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic              accept, drain;

    // With SKID=0 the ready flop only masks the reset window; the stall term is combinational.
    assign in_ready  = (SKID != 0) ? in_ready_q
                                   : (in_ready_q && ((state_q == S_EMPTY) || out_ready));
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Next-state and entry movement; flush overrides everything, dropping any handshake.
    always_comb begin
        state_d      = state_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d     = S_ONE;
                    out_instr_d = in_instr;
                    out_pc_d    = in_pc;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    out_instr_d = in_instr;
                    out_pc_d    = in_pc;
                end else if (accept) begin
                    state_d      = S_FULL;
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (drain) begin
                    state_d     = S_ONE;
                    out_instr_d = skid_instr_q;
                    out_pc_d    = skid_pc_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d = S_EMPTY;
        end
        in_ready_d = (SKID != 0) ? (state_d != S_FULL) : 1'b1;
    end

    // State, ready and held entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            in_ready_q   <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        t_r, t_i, t_s, t_b, t_u, t_j, ill, r_ill;
    logic [31:0] imm32;
    logic [5:0]  dec_type;

    assign opc = out_instr_q[6:0];
    assign f3  = out_instr_q[14:12];
    assign f7  = out_instr_q[31:25];

    // Format classification, illegal-encoding detection and immediate assembly.
    always_comb begin
        t_r   = 1'b0;
        t_i   = 1'b0;
        t_s   = 1'b0;
        t_b   = 1'b0;
        t_u   = 1'b0;
        t_j   = 1'b0;
        ill   = 1'b0;
        r_ill = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
        case (opc)
            7'b0110111, 7'b0010111: t_u = 1'b1;
            7'b1101111: t_j = 1'b1;
            7'b1100111: begin t_i = 1'b1; ill = (f3 != 3'b000); end
            7'b1100011: begin t_b = 1'b1; ill = (f3 == 3'b010) || (f3 == 3'b011); end
            7'b0000011: begin
                t_i = 1'b1;
                ill = (f3[2:1] == 2'b11) || ((XLEN == 32) && (f3 == 3'b011));
            end
            7'b0100011: begin
                t_s = 1'b1;
                ill = (XLEN == 32) ? (f3 >= 3'b011) : (f3 >= 3'b100);
            end
            7'b0010011: begin
                t_i = 1'b1;
                ill = (XLEN == 32) && ((f3 == 3'b001) || (f3 == 3'b101)) && out_instr_q[25];
            end
            7'b0110011: begin t_r = 1'b1; ill = r_ill; end
            7'b0001111, 7'b1110011: t_i = 1'b1;
            7'b0011011: begin t_i = 1'b1; ill = (XLEN == 32); end
            7'b0111011: begin t_r = 1'b1; ill = (XLEN == 32) || r_ill; end
            default: ill = 1'b1;
        endcase
        if (out_instr_q[1:0] != 2'b11) begin
            ill = 1'b1;
        end
        imm32 = '0;
        if (!ill) begin
            if (t_i) imm32 = {{20{out_instr_q[31]}}, out_instr_q[31:20]};
            if (t_s) imm32 = {{20{out_instr_q[31]}}, out_instr_q[31:25], out_instr_q[11:7]};
            if (t_b) imm32 = {{20{out_instr_q[31]}}, out_instr_q[7], out_instr_q[30:25],
                              out_instr_q[11:8], 1'b0};
            if (t_u) imm32 = {out_instr_q[31:12], 12'b0};
            if (t_j) imm32 = {{12{out_instr_q[31]}}, out_instr_q[19:12], out_instr_q[20],
                              out_instr_q[30:21], 1'b0};
        end
        dec_type = ill ? 6'b0 : {t_j, t_u, t_b, t_s, t_i, t_r};
    end

    // Every output reads zero while no bundle is held.
    assign out_pc       = out_valid ? out_pc_q : '0;
    assign out_opcode   = out_valid ? opc : '0;
    assign out_rd       = out_valid ? out_instr_q[11:7] : '0;
    assign out_rs1      = out_valid ? out_instr_q[19:15] : '0;
    assign out_rs2      = out_valid ? out_instr_q[24:20] : '0;
    assign out_funct3   = out_valid ? f3 : '0;
    assign out_funct7   = out_valid ? f7 : '0;
    assign out_type     = out_valid ? dec_type : '0;
    assign out_imm      = out_valid ? {{(XLEN-31){imm32[31]}}, imm32[30:0]} : '0;
    assign out_rd_we    = out_valid && (dec_type[0] || dec_type[1] || dec_type[4] || dec_type[5])
                          && (out_instr_q[11:7] != 5'd0);
    assign out_rs1_used = out_valid && (dec_type[0] || dec_type[1] || dec_type[2] || dec_type[3]);
    assign out_rs2_used = out_valid && (dec_type[0] || dec_type[2] || dec_type[3]);
    assign out_illegal  = out_valid && ill;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: an XLEN=32/SKID=1 instance and an XLEN=64/SKID=0 instance.
module tb_decode_stage_pipe;

    localparam logic [5:0] T_0 = 6'b000000, T_R = 6'b000001, T_I = 6'b000010, T_S = 6'b000100,
                           T_B = 6'b001000, T_U = 6'b010000, T_J = 6'b100000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [5:0]  typ;
        logic [63:0] imm;
        logic        rd_we, rs1u, rs2u, ill;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t q32[$];
    exp_t q64[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1;
    logic [31:0] ins32 = '0, pc32 = '0, opc32_pc, imm32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32;
    logic [5:0]  ty32;
    logic        we32, u1_32, u2_32, il32;

    logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b1;
    logic [31:0] ins64 = '0;
    logic [63:0] pc64 = '0, opc64_pc, imm64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64;
    logic [5:0]  ty64;
    logic        we64, u1_64, u2_64, il64;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .SKID(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv32), .in_ready(ir32), .in_instr(ins32), .in_pc(pc32),
        .out_valid(ov32), .out_ready(or32), .out_pc(opc32_pc),
        .out_opcode(opc32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_funct3(f3_32), .out_funct7(f7_32), .out_type(ty32), .out_imm(imm32),
        .out_rd_we(we32), .out_rs1_used(u1_32), .out_rs2_used(u2_32), .out_illegal(il32)
    );

    decode_stage_pipe #(.XLEN(64), .SKID(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv64), .in_ready(ir64), .in_instr(ins64), .in_pc(pc64),
        .out_valid(ov64), .out_ready(or64), .out_pc(opc64_pc),
        .out_opcode(opc64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_funct3(f3_64), .out_funct7(f7_64), .out_type(ty64), .out_imm(imm64),
        .out_rd_we(we64), .out_rs1_used(u1_64), .out_rs2_used(u2_64), .out_illegal(il64)
    );

    function automatic logic [169:0] exp_vec(input exp_t e, input bit is64);
        logic [63:0] pcm, immm;
        pcm  = is64 ? e.pc  : {32'b0, e.pc[31:0]};
        immm = is64 ? e.imm : {32'b0, e.imm[31:0]};
        return {pcm, e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20],
                e.instr[14:12], e.instr[31:25], e.typ, immm, e.rd_we, e.rs1u, e.rs2u, e.ill};
    endfunction

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [169:0] act, expv;
        exp_t e;
        if (rst_n && ov32 && or32) begin
            checks++;
            act = {32'b0, opc32_pc, opc32, rd32, rs1_32, rs2_32, f3_32, f7_32, ty32,
                   32'b0, imm32, we32, u1_32, u2_32, il32};
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL x32_unexpected_output got %h", act);
            end else begin
                e = q32.pop_front();
                expv = exp_vec(e, 1'b0);
                if (act !== expv) begin
                    errors++;
                    $display("FAIL x32_bundle pc=%h got %h expected %h", e.pc[31:0], act, expv);
                end
            end
        end
        if (rst_n && ov64 && or64) begin
            checks++;
            act = {opc64_pc, opc64, rd64, rs1_64, rs2_64, f3_64, f7_64, ty64,
                   imm64, we64, u1_64, u2_64, il64};
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL x64_unexpected_output got %h", act);
            end else begin
                e = q64.pop_front();
                expv = exp_vec(e, 1'b1);
                if (act !== expv) begin
                    errors++;
                    $display("FAIL x64_bundle pc=%h got %h expected %h", e.pc, act, expv);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [31:0] ins, input logic [63:0] pc);
        if (sel) begin iv64 = v; ins64 = ins; pc64 = pc; end
        else begin iv32 = v; ins32 = ins; pc32 = pc[31:0]; end
    endtask

    // Offer one instruction until accepted; the expectation is queued at the accepting edge.
    task automatic send(input bit sel, input logic [31:0] ins, input logic [63:0] pc,
                        input logic [5:0] typ, input logic [63:0] imm,
                        input logic we, input logic u1, input logic u2, input logic il);
        exp_t e;
        bit acc;
        int n;
        e = '{pc: pc, instr: ins, typ: typ, imm: imm, rd_we: we, rs1u: u1, rs2u: u2, ill: il};
        drive(sel, 1'b1, ins, pc);
        acc = 1'b0;
        n = 0;
        while (!acc) begin
            @(negedge clk);
            acc = sel ? (iv64 && ir64) : (iv32 && ir32);
            @(posedge clk);
            if (acc) begin
                if (sel) q64.push_back(e);
                else q32.push_back(e);
            end
            #1;
            n++;
            if (!acc && n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout sel=%0d pc=%h", sel, pc);
                break;
            end
        end
        drive(sel, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q32.size() != 0 || q64.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d/%0d pending expected 0", q32.size(), q64.size());
        end
    endtask

    task automatic do_flush(input logic [31:0] ins, input logic [63:0] pc);
        flush = 1'b1;
        drive(1'b0, 1'b1, ins, pc);
        @(posedge clk);
        q32.delete();
        q64.delete();
        #1;
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    initial begin
        #2;
        check("reset_out_valid", {63'b0, ov32}, 64'd0);
        check("reset_in_ready", {63'b0, ir32}, 64'd0);
        check("reset_data", {26'b0, ty32, imm32}, 64'd0);
        check("reset_illegal", {63'b0, il32}, 64'd0);
        check("reset_in_ready64", {63'b0, ir64}, 64'd0);
        #18;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {62'b0, ir32, ir64}, 64'd3);

        send(0, 32'hFFF10093, 64'h1000, T_I, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 0, 0);
        check("latency_valid", {63'b0, ov32}, 64'd1);
        check("latency_pc", {32'b0, opc32_pc}, 64'h1000);
        send(0, 32'h00112423, 64'h1004, T_S, 64'd8, 0, 1, 1, 0);
        send(0, 32'h0080006F, 64'h1008, T_J, 64'd8, 0, 0, 0, 0);
        send(0, 32'h00000000, 64'h100C, T_0, 64'd0, 0, 0, 0, 1);
        send(0, 32'h0000A003, 64'h1010, T_I, 64'd0, 0, 1, 0, 0);
        send(0, 32'h0000B003, 64'h1014, T_0, 64'd0, 0, 0, 0, 1);
        send(0, 32'h002081B3, 64'h1018, T_R, 64'd0, 1, 1, 1, 0);
        send(0, 32'h123452B7, 64'h101C, T_U, 64'h12345000, 1, 0, 0, 0);
        send(0, 32'hFE208EE3, 64'h1020, T_B, 64'hFFFFFFFF_FFFFFFFC, 0, 1, 1, 0);
        send(0, 32'h02009093, 64'h1024, T_0, 64'd0, 0, 0, 0, 1);
        send(0, 32'h0010809B, 64'h1028, T_0, 64'd0, 0, 0, 0, 1);
        wait_empty();

        // Stall: two accepts fill out+skid, third offer waits.
        or32 = 1'b0;
        send(0, 32'hFFF10093, 64'h0, T_I, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 0, 0);
        send(0, 32'h00112423, 64'h4, T_S, 64'd8, 0, 1, 1, 0);
        check("stall_in_ready_low", {63'b0, ir32}, 64'd0);
        drive(0, 1'b1, 32'h0080006F, 64'h8);
        cycles(2);
        check("stall_hold_pc", {32'b0, opc32_pc}, 64'h0);
        check("stall_in_ready_still_low", {63'b0, ir32}, 64'd0);
        or32 = 1'b1;
        send(0, 32'h0080006F, 64'h8, T_J, 64'd8, 0, 0, 0, 0);
        wait_empty();

        // Flush while FULL with an offered instruction.
        or32 = 1'b0;
        send(0, 32'h002081B3, 64'h100, T_R, 64'd0, 1, 1, 1, 0);
        send(0, 32'h002081B3, 64'h104, T_R, 64'd0, 1, 1, 1, 0);
        do_flush(32'h123452B7, 64'h108);
        check("flush_full_valid", {63'b0, ov32}, 64'd0);
        check("flush_full_ready", {63'b0, ir32}, 64'd1);
        or32 = 1'b1;
        cycles(3);

        // Flush in ONE where the same-cycle handshake must be discarded.
        or32 = 1'b0;
        send(0, 32'h00112423, 64'h200, T_S, 64'd8, 0, 1, 1, 0);
        do_flush(32'h0080006F, 64'h204);
        check("flush_one_valid", {63'b0, ov32}, 64'd0);
        or32 = 1'b1;
        cycles(2);
        send(0, 32'hFE208EE3, 64'h300, T_B, 64'hFFFFFFFF_FFFFFFFC, 0, 1, 1, 0);
        wait_empty();

        // XLEN=64 instance.
        send(1, 32'h0010809B, 64'h80000000_00000010, T_I, 64'd1, 1, 1, 0, 0);
        send(1, 32'h0000B003, 64'h80000000_00000014, T_I, 64'd0, 0, 1, 0, 0);
        send(1, 32'hFFF10093, 64'h80000000_00000018, T_I, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 0, 0);
        send(1, 32'h02009093, 64'h80000000_0000001C, T_I, 64'd32, 1, 1, 0, 0);
        send(1, 32'hFE208EE3, 64'h80000000_00000020, T_B, 64'hFFFFFFFF_FFFFFFFC, 0, 1, 1, 0);
        wait_empty();

        // Reset mid-stream with both entries held.
        or32 = 1'b0;
        send(0, 32'hFFF10093, 64'h400, T_I, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 0, 0);
        send(0, 32'h00112423, 64'h404, T_S, 64'd8, 0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        q32.delete();
        #1;
        check("midreset_out_valid", {63'b0, ov32}, 64'd0);
        check("midreset_in_ready", {63'b0, ir32}, 64'd0);
        or32 = 1'b1;
        cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postreset_ready", {63'b0, ir32}, 64'd1);
        check("postreset_valid", {63'b0, ov32}, 64'd0);
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
